muldiv_unit: RTL and testbench

Iterative 64-bit multiply/divide unit in the EX stage. It executes the RV64M MUL/DIV/DIVU/REM/REMU operations and their W variants over multiple cycles. The completed result, destination register and write-enable drive the EX-side forwarding inputs (data, valid, dst) of the operand-forwarding logic and the EX/MEM pipeline register. A valid/ready handshake lets the hazard logic stall the front end while the unit is busy.

---
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: one radix-2 shift-add or restoring
// shift-subtract step per cycle, fixed latency per operand width.
module muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 64,
  parameter int unsigned W_CYCLES   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic        is_w,
  input  logic [63:0] srca,
  input  logic [63:0] srcb,
  input  logic [4:0]  dst,
  input  logic        wen,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic [4:0]  out_dst,
  output logic        fwd_valid
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_div_q, is_div_d, is_rem_q, is_rem_d, is_w_q, is_w_d;
  logic            wen_q, wen_d, qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;
  logic [4:0]      dst_q, dst_d;
  logic [63:0]     acc_q, acc_d, x_q, x_d, y_q, y_d, result_q, result_d;

  logic            op_div, op_sgn, op_rem, a_neg, b_neg, last, ge;
  logic [63:0]     a_ext, b_ext, a_mag, b_mag;
  logic [64:0]     rem_sh, diff;
  logic [63:0]     acc_step, x_step, y_step, q_fix, r_fix, raw_res, fin_res;

  // Operand decode: operative-width extension, then magnitudes for signed divides.
  always_comb begin
    op_div = (op >= 3'd1) && (op <= 3'd4);
    op_sgn = (op == 3'd1) || (op == 3'd3);
    op_rem = (op == 3'd3) || (op == 3'd4);
    a_ext  = srca;
    b_ext  = srcb;
    if (is_w) begin
      a_ext = op_sgn ? {{32{srca[31]}}, srca[31:0]} : {32'b0, srca[31:0]};
      b_ext = op_sgn ? {{32{srcb[31]}}, srcb[31:0]} : {32'b0, srcb[31:0]};
    end
    a_neg = op_sgn & a_ext[63];
    b_neg = op_sgn & b_ext[63];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  // One iteration; the borrow of the 65-bit difference is the restore decision.
  always_comb begin
    rem_sh = {acc_q, x_q[63]};
    diff   = rem_sh - {1'b0, y_q};
    ge     = ~diff[64];
    if (is_div_q) begin
      acc_step = ge ? diff[63:0] : rem_sh[63:0];
      x_step   = {x_q[62:0], ge};
      y_step   = y_q;
    end else begin
      acc_step = acc_q + (y_q[0] ? x_q : 64'd0);
      x_step   = {x_q[62:0], 1'b0};
      y_step   = {1'b0, y_q[63:1]};
    end
    q_fix   = div0_q ? '1 : (qneg_q ? -x_step : x_step);
    r_fix   = rneg_q ? -acc_step : acc_step;
    raw_res = !is_div_q ? acc_step : (is_rem_q ? r_fix : q_fix);
    fin_res = is_w_q ? {{32{raw_res[31]}}, raw_res[31:0]} : raw_res;
  end

  assign last = (cnt_q == CntW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (in_valid) state_d = StBusy;
        StBusy:  if (last) state_d = StDone;
        StDone:  if (out_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    is_rem_d = is_rem_q;
    is_w_d   = is_w_q;
    wen_d    = wen_q;
    dst_d    = dst_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    if (flush) begin
      cnt_d = '0;
    end else if (state_q == StIdle && in_valid) begin
      cnt_d    = is_w ? CntW'(W_CYCLES) : CntW'(MUL_CYCLES);
      is_div_d = op_div;
      is_rem_d = op_rem;
      is_w_d   = is_w;
      wen_d    = wen;
      dst_d    = dst;
      qneg_d   = a_neg ^ b_neg;
      rneg_d   = a_neg;
      div0_d   = op_div && (b_ext == 64'd0);
      acc_d    = '0;
      // W divides pre-align the dividend so 32 steps consume exactly its bits.
      x_d      = !op_div ? srca : (is_w ? {a_mag[31:0], 32'b0} : a_mag);
      y_d      = op_div ? b_mag : srcb;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - CntW'(1);
      acc_d = acc_step;
      x_d   = x_step;
      y_d   = y_step;
      if (last) result_d = fin_res;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      is_rem_q <= 1'b0;
      is_w_q   <= 1'b0;
      wen_q    <= 1'b0;
      dst_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      is_rem_q <= is_rem_d;
      is_w_q   <= is_w_d;
      wen_q    <= wen_d;
      dst_q    <= dst_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    fwd_valid = out_valid & wen_q;
    result    = result_q;
    out_dst   = dst_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, arithmetic corner cases,
// back-pressure, flush and asynchronous reset.
module tb_muldiv_unit;

  logic        clk, reset, flush, in_valid, in_ready, is_w, wen;
  logic        out_valid, out_ready, fwd_valid;
  logic [2:0]  op;
  logic [63:0] srca, srcb, result;
  logic [4:0]  dst, out_dst;
  int          n_cmp, n_fail;

  muldiv_unit #(.MUL_CYCLES(64), .W_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .is_w(is_w), .srca(srca), .srcb(srcb), .dst(dst), .wen(wen),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_dst(out_dst),
    .fwd_valid(fwd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request, return in_ready just after the accept edge and the
  // number of edges until out_valid (-1 if it never came).
  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] d, input logic we,
                        output logic rdy_after, output int lat);
    @(negedge clk);
    op = o; is_w = w; srca = a; srcb = b; dst = d; wen = we; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_after = in_ready;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic consume();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valids got %b%b want 00", out_valid, fwd_valid); end
    n_cmp++; if (result !== 64'd0 || out_dst !== 5'd0) begin n_fail++; $display("FAIL reset_data got %h/%0d want 0/0", result, out_dst); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mul();
    logic r; int lat;
    run_op(3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd5, 1'b1, r, lat);
    n_cmp++; if (r !== 1'b0) begin n_fail++; $display("FAIL mul_busy_ready got %b want 0", r); end
    n_cmp++; if (lat != 64) begin n_fail++; $display("FAIL mul_latency got %0d want 64", lat); end
    n_cmp++; if (result !== 64'hFFFFFFFFFFFFFFEB) begin n_fail++; $display("FAIL mul_result got %h want ffffffffffffffeb", result); end
    n_cmp++; if (out_dst !== 5'd5 || fwd_valid !== 1'b1) begin n_fail++; $display("FAIL mul_fwd got dst=%0d fwd=%b want 5/1", out_dst, fwd_valid); end
    consume();
    run_op(3'd5, 1'b0, 64'd6, 64'd7, 5'd9, 1'b0, r, lat);
    n_cmp++; if (result !== 64'd42) begin n_fail++; $display("FAIL op5_mul got %h want 2a", result); end
    n_cmp++; if (fwd_valid !== 1'b0 || out_dst !== 5'd9) begin n_fail++; $display("FAIL nowen_fwd got fwd=%b dst=%0d want 0/9", fwd_valid, out_dst); end
    consume();
  endtask

  task automatic test_div();
    logic r; int lat;
    run_op(3'd1, 1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd3, 5'd1, 1'b1, r, lat);
    n_cmp++; if (lat != 64) begin n_fail++; $display("FAIL div_latency got %0d want 64", lat); end
    n_cmp++; if (result !== 64'hFFFFFFFFFFFFFFFA) begin n_fail++; $display("FAIL div_neg got %h want fffffffffffffffa", result); end
    consume();
    run_op(3'd3, 1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd3, 5'd1, 1'b1, r, lat);
    n_cmp++; if (result !== 64'hFFFFFFFFFFFFFFFE) begin n_fail++; $display("FAIL rem_neg got %h want fffffffffffffffe", result); end
    consume();
    run_op(3'd2, 1'b0, 64'd20, 64'd3, 5'd1, 1'b1, r, lat);
    n_cmp++; if (result !== 64'd6) begin n_fail++; $display("FAIL divu got %h want 6", result); end
    consume();
    run_op(3'd4, 1'b0, 64'd20, 64'd3, 5'd1, 1'b1, r, lat);
    n_cmp++; if (result !== 64'd2) begin n_fail++; $display("FAIL remu got %h want 2", result); end
    consume();
  endtask

  task automatic test_special();
    logic r; int lat;
    run_op(3'd2, 1'b0, 64'h1234, 64'd0, 5'd2, 1'b1, r, lat);
    n_cmp++; if (lat != 64) begin n_fail++; $display("FAIL div0_latency got %0d want 64", lat); end
    n_cmp++; if (result !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL divu0 got %h want ffffffffffffffff", result); end
    consume();
    run_op(3'd4, 1'b0, 64'h1234, 64'd0, 5'd2, 1'b1, r, lat);
    n_cmp++; if (result !== 64'h1234) begin n_fail++; $display("FAIL remu0 got %h want 1234", result); end
    consume();
    run_op(3'd1, 1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd0, 5'd2, 1'b1, r, lat);
    n_cmp++; if (result !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL div0_signed got %h want ffffffffffffffff", result); end
    consume();
    run_op(3'd3, 1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd0, 5'd2, 1'b1, r, lat);
    n_cmp++; if (result !== 64'hFFFFFFFFFFFFFFEC) begin n_fail++; $display("FAIL rem0_signed got %h want ffffffffffffffec", result); end
    consume();
    run_op(3'd1, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd2, 1'b1, r, lat);
    n_cmp++; if (lat != 64) begin n_fail++; $display("FAIL ovf_latency got %0d want 64", lat); end
    n_cmp++; if (result !== 64'h8000000000000000) begin n_fail++; $display("FAIL div_ovf got %h want 8000000000000000", result); end
    consume();
    run_op(3'd3, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd2, 1'b1, r, lat);
    n_cmp++; if (result !== 64'd0) begin n_fail++; $display("FAIL rem_ovf got %h want 0", result); end
    consume();
  endtask

  task automatic test_w();
    logic r; int lat;
    run_op(3'd1, 1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF, 5'd3, 1'b1, r, lat);
    n_cmp++; if (lat != 32) begin n_fail++; $display("FAIL divw_latency got %0d want 32", lat); end
    n_cmp++; if (result !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL divw_ovf got %h want ffffffff80000000", result); end
    consume();
    run_op(3'd0, 1'b1, 64'h10000, 64'h10000, 5'd3, 1'b1, r, lat);
    n_cmp++; if (result !== 64'd0) begin n_fail++; $display("FAIL mulw got %h want 0", result); end
    consume();
    run_op(3'd2, 1'b1, 64'h00000000FFFFFFFE, 64'd1, 5'd3, 1'b1, r, lat);
    n_cmp++; if (result !== 64'hFFFFFFFFFFFFFFFE) begin n_fail++; $display("FAIL divuw got %h want fffffffffffffffe", result); end
    consume();
    run_op(3'd3, 1'b1, 64'h12345678FFFFFFF9, 64'hABCDEF0000000002, 5'd3, 1'b1, r, lat);
    n_cmp++; if (result !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL remw got %h want ffffffffffffffff", result); end
    consume();
    run_op(3'd2, 1'b1, 64'h55, 64'hFFFFFFFF00000000, 5'd3, 1'b1, r, lat);
    n_cmp++; if (result !== 64'hFFFFFFFFFFFFFFFF) begin n_fail++; $display("FAIL divuw0 got %h want ffffffffffffffff", result); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic r; int lat; int bad;
    out_ready = 1'b0;
    run_op(3'd0, 1'b0, 64'd100, 64'd25, 5'd17, 1'b1, r, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (result !== 64'd2500 || fwd_valid !== 1'b1 || out_valid !== 1'b1 ||
          out_dst !== 5'd17 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL backpressure_hold got %0d bad cycles want 0 (result %h)", bad, result); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL release_ready got rdy=%b ov=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_flush();
    int rose;
    @(negedge clk);
    op = 3'd1; is_w = 1'b0; srca = 64'd99; srcb = 64'd9; dst = 5'd4; wen = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", in_ready); end
    rose = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) rose++;
    end
    n_cmp++; if (rose != 0) begin n_fail++; $display("FAIL flush_no_valid got %0d valid cycles want 0", rose); end
    @(negedge clk); in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_accept got in_ready %b want 1", in_ready); end
    rose = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) rose++;
    end
    n_cmp++; if (rose != 0) begin n_fail++; $display("FAIL flush_idle_quiet got %0d active cycles want 0", rose); end
  endtask

  task automatic test_async_reset();
    logic r; int lat;
    run_op(3'd0, 1'b0, 64'd11, 64'd13, 5'd21, 1'b1, r, lat);
    consume();
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; srca = 64'd5; srcb = 64'd5;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2; reset = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctl got rdy=%b ov=%b fwd=%b want 1/0/0", in_ready, out_valid, fwd_valid); end
    n_cmp++; if (result !== 64'd0 || out_dst !== 5'd0) begin n_fail++; $display("FAIL async_reset_data got %h/%0d want 0/0", result, out_dst); end
    @(negedge clk); reset = 1'b0;
    run_op(3'd0, 1'b0, 64'd3, 64'd4, 5'd6, 1'b1, r, lat);
    n_cmp++; if (lat != 64 || result !== 64'd12) begin n_fail++; $display("FAIL post_reset_mul got lat=%0d res=%h want 64/c", lat, result); end
    consume();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'd0; is_w = 1'b0; srca = '0; srcb = '0; dst = '0; wen = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_w();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
